// File: rtl/pwm_gen_mc.sv
// Multi-channel PWM generator: one shared period counter (edge- or center-aligned)
// with per-channel duty/polarity, shadowed configuration applied at period boundaries.
module pwm_gen_mc #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_en,
  input  logic                      i_cfg_wr,
  input  logic [WIDTH-1:0]          i_cfg_period,
  input  logic [CHANNELS*WIDTH-1:0] i_cfg_duty,
  input  logic [CHANNELS-1:0]       i_cfg_pol,
  input  logic                      i_cfg_center,
  output logic [CHANNELS-1:0]       o_pwm_out,
  output logic                      o_period_tick,
  output logic                      o_cfg_pending
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {ST_UP = 1'b0, ST_DOWN = 1'b1} dir_t;

  dir_t                      r_state;
  dir_t                      w_state_nxt;
  logic [WIDTH-1:0]          r_cnt;
  logic [WIDTH-1:0]          w_cnt_nxt;
  logic [WIDTH-1:0]          w_last;
  logic                      w_run;
  logic                      w_boundary;
  logic                      w_apply;
  logic [CHANNELS-1:0]       w_cmp;

  logic [WIDTH-1:0]          r_pnd_period;
  logic [CHANNELS*WIDTH-1:0] r_pnd_duty;
  logic [CHANNELS-1:0]       r_pnd_pol;
  logic                      r_pnd_center;
  logic [WIDTH-1:0]          r_act_period;
  logic [CHANNELS*WIDTH-1:0] r_act_duty;
  logic [CHANNELS-1:0]       r_act_pol;
  logic                      r_act_center;

  // Counter/direction next state; a direction flip doubles as the endpoint hold in center mode
  always_comb begin
    w_cnt_nxt   = ZERO;
    w_state_nxt = ST_UP;
    w_boundary  = 1'b0;
    w_last      = r_act_period - ONE;
    w_run       = i_en && (r_act_period != ZERO);
    if (!w_run) begin
      w_cnt_nxt   = ZERO;
      w_state_nxt = ST_UP;
    end else if (r_act_center) begin
      case (r_state)
        ST_UP: begin
          if (r_cnt >= w_last) begin
            w_cnt_nxt   = r_cnt;
            w_state_nxt = ST_DOWN;
          end else begin
            w_cnt_nxt   = r_cnt + ONE;
            w_state_nxt = ST_UP;
          end
        end
        ST_DOWN: begin
          if (r_cnt == ZERO) begin
            w_boundary  = 1'b1;
            w_cnt_nxt   = ZERO;
            w_state_nxt = ST_UP;
          end else begin
            w_cnt_nxt   = r_cnt - ONE;
            w_state_nxt = ST_DOWN;
          end
        end
        default: begin
          w_cnt_nxt   = ZERO;
          w_state_nxt = ST_UP;
        end
      endcase
    end else begin
      if (r_cnt >= w_last) begin
        w_boundary = 1'b1;
        w_cnt_nxt  = ZERO;
      end else begin
        w_cnt_nxt  = r_cnt + ONE;
      end
    end
    w_apply = r_pending_apply_ok(o_cfg_pending, w_run, w_boundary);
  end

  function automatic logic r_pending_apply_ok(input logic pend, input logic run, input logic bnd);
    return pend && (!run || bnd);
  endfunction

  // Per-channel compare; a stopped or zero-period block shows the inactive level
  always_comb begin
    w_cmp = r_act_pol;
    if (w_run) begin
      for (int i = 0; i < CHANNELS; i++) begin
        w_cmp[i] = r_act_pol[i] ^ (r_cnt < r_act_duty[i*WIDTH +: WIDTH]);
      end
    end else begin
      w_cmp = r_act_pol;
    end
  end

  // Counter, direction and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_UP;
      r_cnt         <= ZERO;
      o_pwm_out     <= {CHANNELS{1'b0}};
      o_period_tick <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      o_pwm_out     <= w_cmp;
      o_period_tick <= w_boundary;
    end
  end

  // Shadow registers: apply copies the old pending set even when a new write lands the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pnd_period  <= ZERO;
      r_pnd_duty    <= {(CHANNELS*WIDTH){1'b0}};
      r_pnd_pol     <= {CHANNELS{1'b0}};
      r_pnd_center  <= 1'b0;
      r_act_period  <= ZERO;
      r_act_duty    <= {(CHANNELS*WIDTH){1'b0}};
      r_act_pol     <= {CHANNELS{1'b0}};
      r_act_center  <= 1'b0;
      o_cfg_pending <= 1'b0;
    end else begin
      if (i_cfg_wr) begin
        r_pnd_period <= i_cfg_period;
        r_pnd_duty   <= i_cfg_duty;
        r_pnd_pol    <= i_cfg_pol;
        r_pnd_center <= i_cfg_center;
      end
      if (w_apply) begin
        r_act_period <= r_pnd_period;
        r_act_duty   <= r_pnd_duty;
        r_act_pol    <= r_pnd_pol;
        r_act_center <= r_pnd_center;
      end
      if (i_cfg_wr) begin
        o_cfg_pending <= 1'b1;
      end else if (w_apply) begin
        o_cfg_pending <= 1'b0;
      end else begin
        o_cfg_pending <= o_cfg_pending;
      end
    end
  end

endmodule

// File: tb/tb_pwm_gen_mc.sv
// Directed self-checking bench for pwm_gen_mc: vector table for edge/center waveforms,
// hand-written sequences for shadowing, enable, degenerate periods and async reset.
module tb_pwm_gen_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        wr;
  logic [7:0]  per;
  logic [31:0] duty;
  logic [3:0]  pol;
  logic        ctr;
  logic [3:0]  pwm;
  logic        tick;
  logic        pend;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        en;
    logic        wr;
    logic [7:0]  per;
    logic [31:0] duty;
    logic [3:0]  pol;
    logic        ctr;
    logic [3:0]  e_pwm;
    logic        e_tick;
    logic        e_pend;
  } vec_t;

  vec_t vecs[$];

  pwm_gen_mc #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_en          (en),
    .i_cfg_wr      (wr),
    .i_cfg_period  (per),
    .i_cfg_duty    (duty),
    .i_cfg_pol     (pol),
    .i_cfg_center  (ctr),
    .o_pwm_out     (pwm),
    .o_period_tick (tick),
    .o_cfg_pending (pend)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] e_pwm, input logic e_tick, input logic e_pend);
    n_tests++;
    if (pwm !== e_pwm) begin
      n_fail++;
      $display("FAIL %s pwm_out got %b want %b", nm, pwm, e_pwm);
    end
    n_tests++;
    if (tick !== e_tick) begin
      n_fail++;
      $display("FAIL %s period_tick got %b want %b", nm, tick, e_tick);
    end
    n_tests++;
    if (pend !== e_pend) begin
      n_fail++;
      $display("FAIL %s cfg_pending got %b want %b", nm, pend, e_pend);
    end
  endtask

  task automatic drive(input logic e, input logic w, input logic [7:0] p, input logic [31:0] d,
                       input logic [3:0] pl, input logic c);
    en = e; wr = w; per = p; duty = d; pol = pl; ctr = c;
  endtask

  function automatic vec_t mk(input logic e, input logic w, input logic [7:0] p, input logic [31:0] d,
                              input logic [3:0] pl, input logic c, input logic [3:0] ep,
                              input logic et, input logic epd);
    vec_t v;
    v.en = e; v.wr = w; v.per = p; v.duty = d; v.pol = pl; v.ctr = c;
    v.e_pwm = ep; v.e_tick = et; v.e_pend = epd;
    return v;
  endfunction

  initial begin
    logic [31:0] d_edge;
    logic [31:0] d_ctr;
    logic [7:0]  d0w;
    int          cs[8];
    int          dact[4];

    d_edge = {8'd255, 8'd10, 8'd3, 8'd0};
    d_ctr  = {8'd1, 8'd4, 8'd0, 8'd2};
    cs     = '{0, 1, 2, 3, 3, 2, 1, 0};
    dact   = '{4, 6, 5, 2};

    // Edge-aligned P=10 table, then center-aligned P=4 table
    vecs.push_back(mk(1'b0, 1'b1, 8'd10, d_edge, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd10, d_edge, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
    for (int k = 0; k < 20; k++) begin
      vecs.push_back(mk(1'b1, 1'b0, 8'd10, d_edge, 4'b0000, 1'b0,
                        {2'b11, ((k % 10) < 3), 1'b0}, ((k % 10) == 9), 1'b0));
    end
    vecs.push_back(mk(1'b0, 1'b1, 8'd4, d_ctr, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd4, d_ctr, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0));
    for (int k = 0; k < 16; k++) begin
      vecs.push_back(mk(1'b1, 1'b0, 8'd4, d_ctr, 4'b0000, 1'b1,
                        {(cs[k % 8] < 1), 1'b1, 1'b0, (cs[k % 8] < 2)}, ((k % 8) == 7), 1'b0));
    end

    rst = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 32'd0, 4'b0000, 1'b0);
    step();
    step();
    chk("reset", 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].wr, vecs[i].per, vecs[i].duty, vecs[i].pol, vecs[i].ctr);
      step();
      chk($sformatf("vec%0d", i), vecs[i].e_pwm, vecs[i].e_tick, vecs[i].e_pend);
    end

    // Shadow: P=8, D0=4, ch1 inverted with D=0, ch2 D=P
    drive(1'b0, 1'b1, 8'd8, {8'd0, 8'd8, 8'd0, 8'd4}, 4'b0010, 1'b0);
    step();
    chk("sh_wr", 4'b0000, 1'b0, 1'b1);
    wr = 1'b0;
    step();
    chk("sh_apply", 4'b0000, 1'b0, 1'b0);
    step();
    chk("en0_pol", 4'b0010, 1'b0, 1'b0);
    for (int k = 0; k < 32; k++) begin
      d0w = (k == 2) ? 8'd6 : (k == 11) ? 8'd7 : (k == 12) ? 8'd5 : 8'd2;
      drive(1'b1, ((k == 2) || (k == 11) || (k == 12) || (k == 15)), 8'd8,
            {8'd0, 8'd8, 8'd0, d0w}, 4'b0010, 1'b0);
      step();
      chk($sformatf("shadow k%0d", k), {3'b011, ((k % 8) < dact[k / 8])}, ((k % 8) == 7),
          (((k >= 2) && (k <= 6)) || ((k >= 11) && (k <= 22))));
    end

    // Drop enable at counter 5, then a full first period after re-enable
    wr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("pre_drop k%0d", k), {3'b011, (k < 2)}, 1'b0, 1'b0);
    end
    en = 1'b0;
    step();
    chk("en_drop", 4'b0010, 1'b0, 1'b0);
    step();
    chk("en_off", 4'b0010, 1'b0, 1'b0);
    en = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step();
      chk($sformatf("reen j%0d", j), {3'b011, (j < 2)}, (j == 7), 1'b0);
    end

    // P=0 then P=1 (applied on the next edge while P=0 is active)
    drive(1'b0, 1'b1, 8'd0, 32'd0, 4'b1010, 1'b0);
    step();
    chk("p0_wr", 4'b0010, 1'b0, 1'b1);
    wr = 1'b0;
    step();
    chk("p0_apply", 4'b0010, 1'b0, 1'b0);
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("p0_run%0d", k), 4'b1010, 1'b0, 1'b0);
    end
    drive(1'b1, 1'b1, 8'd1, {8'd1, 8'd1, 8'd1, 8'd0}, 4'b0000, 1'b0);
    step();
    chk("p1_wr", 4'b1010, 1'b0, 1'b1);
    wr = 1'b0;
    step();
    chk("p1_apply", 4'b1010, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("p1_run%0d", k), 4'b1110, 1'b1, 1'b0);
    end

    // Asynchronous reset mid-period with a write pending
    drive(1'b1, 1'b1, 8'd8, {8'd9, 8'd9, 8'd9, 8'd9}, 4'b1111, 1'b0);
    step();
    chk("rst_pre", 4'b1110, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", 4'b0000, 1'b0, 1'b0);
    wr = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post_rst%0d", k), 4'b0000, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
